// File: rtl/extensor_pkg.sv
// Purpose: shared modo encodings and default widths for the immediate extender.
// Latency: n/a (constants only).
// Backpressure: n/a.
package extensor_pkg;

   // modo[1] selects the field, modo[0] selects zero-fill (1) or sign-fill (0)
   localparam logic [1:0] MODO_S16 = 2'b00;
   localparam logic [1:0] MODO_Z16 = 2'b01;
   localparam logic [1:0] MODO_S21 = 2'b10;
   localparam logic [1:0] MODO_Z21 = 2'b11;

   localparam int DATA_W_DEF = 32;
   localparam int IN_A_W_DEF = 16;
   localparam int IN_B_W_DEF = 21;
   localparam int SH_W_DEF   = 4;

endpackage

// File: rtl/extensor_estagio.sv
// Purpose: generic valid/ready register slice, data loads only on input transfer.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream. Data and valid reset to 0.
module extensor_estagio #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // A full slice can still accept when its content leaves in the same cycle.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/extensor_pipe.sv
// Purpose: two-stage immediate extender: field select + sign/zero extend, then left shift with overflow flag.
// Latency: input transfer at edge N presents out_valid after edge N+1 (consumed at edge N+2); 1 item/cycle.
// Backpressure: valid/ready; out_ready ripples combinationally through both slices to in_ready.
// Ports: clk, rst_n, in_valid/in_ready, in16, in21, modo, desloc upstream;
//        out_valid/out_ready, extendido, ovf downstream.
// Build option: EXTENSOR_OVF_EN builds shift-overflow detection; otherwise ovf is tied to 0.
module extensor_pipe
   import extensor_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IN_A_W = IN_A_W_DEF,
   parameter int IN_B_W = IN_B_W_DEF,
   parameter int SH_W   = SH_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_A_W-1:0] in16,
   input  logic [IN_B_W-1:0] in21,
   input  logic [1:0]        modo,
   input  logic [SH_W-1:0]   desloc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] extendido,
   output logic              ovf
);

   // ---------------- extension (feeds stage 1) ----------------
   logic [DATA_W-1:0] ext_c;

   always_comb begin
      ext_c = '0;
      case (modo)
         MODO_S16: ext_c = {{(DATA_W-IN_A_W){in16[IN_A_W-1]}}, in16};
         MODO_Z16: ext_c = {{(DATA_W-IN_A_W){1'b0}}, in16};
         MODO_S21: ext_c = {{(DATA_W-IN_B_W){in21[IN_B_W-1]}}, in21};
         default:  ext_c = {{(DATA_W-IN_B_W){1'b0}}, in21};
      endcase
   end

   // Stage 1 payload: extended value and shift amount; the fill mode is only
   // carried forward when overflow detection needs it.
`ifdef EXTENSOR_OVF_EN
   localparam int S1_W = DATA_W + SH_W + 1;
   localparam int S2_W = DATA_W + 1;
`else
   localparam int S1_W = DATA_W + SH_W;
   localparam int S2_W = DATA_W;
`endif

   logic [S1_W-1:0]   s1_in, s1_out;
   logic [S2_W-1:0]   s2_in, s2_out;
   logic              v1, ready2;
   logic [DATA_W-1:0] s1_val, shl;
   logic [SH_W-1:0]   s1_sh;

`ifdef EXTENSOR_OVF_EN
   assign s1_in = {modo[0], ext_c, desloc};
`else
   assign s1_in = {ext_c, desloc};
`endif

   extensor_estagio #(.W(S1_W)) u_st1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in),
      .out_valid (v1),
      .out_ready (ready2),
      .out_data  (s1_out)
   );

   // ---------------- shift / overflow (feeds stage 2) ----------------
   assign s1_val = s1_out[SH_W +: DATA_W];
   assign s1_sh  = s1_out[SH_W-1:0];
   assign shl    = s1_val << s1_sh;

`ifdef EXTENSOR_OVF_EN
   logic s1_zero, ovf_c;
   assign s1_zero = s1_out[S1_W-1];

   // Shifting back recovers the original only if the discarded bits were
   // pure fill: zeros for zero modes, copies of the result MSB for signed.
   always_comb begin
      ovf_c = 1'b0;
      if (s1_zero)
         ovf_c = ((shl >> s1_sh) != s1_val);
      else
         ovf_c = (($signed(shl) >>> s1_sh) != $signed(s1_val));
   end

   assign s2_in = {shl, ovf_c};
`else
   assign s2_in = shl;
`endif

   extensor_estagio #(.W(S2_W)) u_st2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v1),
      .in_ready  (ready2),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_out)
   );

`ifdef EXTENSOR_OVF_EN
   assign extendido = s2_out[S2_W-1:1];
   assign ovf       = s2_out[0];
`else
   assign extendido = s2_out;
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_extensor_pipe.sv
module tb_extensor_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in16;
   logic [20:0] in21;
   logic [1:0]  modo;
   logic [3:0]  desloc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] extendido;
   logic        ovf;

   int passed = 0;
   int total  = 0;

`ifdef EXTENSOR_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [1:0]  m;
      logic [15:0] a;
      logic [20:0] b;
      logic [3:0]  d;
      logic [31:0] e;
      logic        o;
   } vec_t;

   extensor_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in16      (in16),
      .in21      (in21),
      .modo      (modo),
      .desloc    (desloc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .extendido (extendido),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      modo   = v.m;
      in16   = v.a;
      in21   = v.b;
      desloc = v.d;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in16 = '0; in21 = '0; modo = '0; desloc = '0;
      #3;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (extendido !== 32'h0) $display("FAIL reset_extendido got %h want 00000000", extendido); else passed++;
      total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got %b want 0", out_valid); else passed++;
   endtask

   // ------------------------------------------------------------------
   task automatic test_extend();
      vec_t v[8];
      v[0] = '{2'b00, 16'h8001, 21'h000000, 4'd0,  32'hFFFF8001, 1'b0};
      v[1] = '{2'b01, 16'h8001, 21'h000000, 4'd0,  32'h00008001, 1'b0};
      v[2] = '{2'b10, 16'h0000, 21'h100000, 4'd2,  32'hFFC00000, 1'b0};
      v[3] = '{2'b11, 16'h0000, 21'h1FFFFF, 4'd3,  32'h00FFFFF8, 1'b0};
      v[4] = '{2'b10, 16'h0000, 21'h0FFFFF, 4'd12, 32'hFFFFF000, OVF_ON};
      v[5] = '{2'b11, 16'h0000, 21'h1FFFFF, 4'd12, 32'hFFFFF000, OVF_ON};
      v[6] = '{2'b00, 16'h0001, 21'h000000, 4'd15, 32'h00008000, 1'b0};
      v[7] = '{2'b00, 16'hFFFF, 21'h000000, 4'd15, 32'hFFFF8000, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(v[i]);
         in_valid = 1'b1;
         total++; if (in_ready !== 1'b1) $display("FAIL ext%0d_in_ready got %b want 1", i, in_ready); else passed++;
         tick();
         // scramble inputs after the transfer; they must not be resampled
         in_valid = 1'b0; modo = ~v[i].m; in16 = ~v[i].a; in21 = ~v[i].b; desloc = ~v[i].d;
         total++; if (out_valid !== 1'b0) $display("FAIL ext%0d_early_valid got %b want 0", i, out_valid); else passed++;
         tick();
         total++; if (out_valid !== 1'b1) $display("FAIL ext%0d_valid got %b want 1", i, out_valid); else passed++;
         total++; if (extendido !== v[i].e) $display("FAIL ext%0d_value got %h want %h", i, extendido, v[i].e); else passed++;
         total++; if (ovf !== v[i].o) $display("FAIL ext%0d_ovf got %b want %b", i, ovf, v[i].o); else passed++;
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL ext%0d_drained got %b want 0", i, out_valid); else passed++;
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [31:0] expq[8];
      int accepted = 0, got = 0, first_cyc = -1;
      logic gap = 1'b0, ready_low = 1'b0, hand;
      for (int i = 0; i < 8; i++)
         expq[i] = {16'h0, (16'h0101 * 16'(i)) + 16'h00F0} << (i % 4);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
         if (accepted < 8) begin
            modo = 2'b01; in21 = '0; desloc = 4'(accepted % 4);
            in16 = (16'h0101 * 16'(accepted)) + 16'h00F0;
            in_valid = 1'b1;
            if (in_ready !== 1'b1) ready_low = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            if (first_cyc < 0) first_cyc = cyc;
            total++; if (extendido !== expq[got]) $display("FAIL b2b_item%0d got %h want %h", got, extendido, expq[got]); else passed++;
            got++;
         end else if (got > 0) begin
            gap = 1'b1;
         end
         hand = in_valid && in_ready;
         tick();
         if (hand) accepted++;
      end
      in_valid = 1'b0;
      total++; if (got !== 8) $display("FAIL b2b_count got %0d want 8", got); else passed++;
      total++; if (first_cyc !== 2) $display("FAIL b2b_first_cycle got %0d want 2", first_cyc); else passed++;
      total++; if (gap !== 1'b0) $display("FAIL b2b_gap got %b want 0", gap); else passed++;
      total++; if (ready_low !== 1'b0) $display("FAIL b2b_in_ready_low got %b want 0", ready_low); else passed++;
   endtask

   // ------------------------------------------------------------------
   task automatic test_stall();
      vec_t v[3];
      int idx = 0, got = 0;
      logic hin;
      v[0] = '{2'b00, 16'h8001, 21'h000000, 4'd0, 32'hFFFF8001, 1'b0};
      v[1] = '{2'b01, 16'h1234, 21'h000000, 4'd4, 32'h00012340, 1'b0};
      v[2] = '{2'b10, 16'h0000, 21'h100000, 4'd2, 32'hFFC00000, 1'b0};
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (idx < 2) drive(v[idx]);
         else begin
            // third item wiggles while blocked; none of this may be captured
            modo = 2'(cyc); desloc = 4'd15; in16 = 16'(cyc * 16'h1111); in21 = 21'h1ABCDE;
         end
         in_valid = 1'b1;
         hin = in_valid && in_ready;
         tick();
         if (hin) idx++;
      end
      total++; if (idx !== 2) $display("FAIL stall_accepted got %0d want 2", idx); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid got %b want 1", out_valid); else passed++;
      total++; if (extendido !== v[0].e) $display("FAIL stall_head got %h want %h", extendido, v[0].e); else passed++;
      drive(v[2]);
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL stall_ready_comb got %b want 1", in_ready); else passed++;
      for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
         if (out_valid === 1'b1) begin
            total++; if (extendido !== v[got].e) $display("FAIL stall_drain%0d got %h want %h", got, extendido, v[got].e); else passed++;
            got++;
         end
         hin = in_valid && in_ready;
         tick();
         if (hin) idx++;
         if (idx >= 3) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      total++; if (got !== 3) $display("FAIL stall_drain_count got %0d want 3", got); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stall_duplicate got %b want 0", out_valid); else passed++;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid();
      vec_t x, z;
      int idx = 0;
      logic hin;
      x = '{2'b00, 16'h7FFF, 21'h000000, 4'd1, 32'h0000FFFE, 1'b0};
      z = '{2'b11, 16'h0000, 21'h0ABCDE, 4'd1, 32'h001579BC, 1'b0};
      out_ready = 1'b0;
      drive(x);
      for (int cyc = 0; cyc < 6 && idx < 2; cyc++) begin
         in_valid = 1'b1;
         hin = in_valid && in_ready;
         tick();
         if (hin) idx++;
      end
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) $display("FAIL rstmid_full got %b want 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre_valid got %b want 1", out_valid); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else passed++;
      total++; if (extendido !== 32'h0) $display("FAIL rstmid_data got %h want 00000000", extendido); else passed++;
      tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_stale got %b want 0", out_valid); else passed++;
      out_ready = 1'b1;
      drive(z);
      in_valid = 1'b1;
      total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else passed++;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_early got %b want 0", out_valid); else passed++;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL rstmid_new_valid got %b want 1", out_valid); else passed++;
      total++; if (extendido !== z.e) $display("FAIL rstmid_new_value got %h want %h", extendido, z.e); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_after got %b want 0", out_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_extend();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule
